conv_win_addr_gen: RTL
======================

CONV_WIN_ADDR_GEN -- requirements
Module: conv_win_addr_gen

Interface
REQ-001 Parameter: ADDR_W, default 16, width of the feature-map address bus.
REQ-002 Parameter: DIM_W, default 8, width of the width/height dimension fields.
REQ-003 Parameter: K_W, default 4, width of the kernel-size field.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to begin one feature-map pass.
REQ-007 cfg_base  input  ADDR_W  feature-map base address.
REQ-008 cfg_width  input  DIM_W  input map width W.
REQ-009 cfg_height  input  DIM_W  input map height H.
REQ-010 cfg_kernel  input  K_W  square kernel size K; stride is fixed at 1.
REQ-011 stall  input  1  downstream hold; while high, the presented address is not consumed.
REQ-012 addr_valid  output  1  addr carries a valid read address.
REQ-013 addr  output  ADDR_W  feature-map read address.
REQ-014 win_last  output  1  addr is the final tap of the current KxK window.
REQ-015 busy  output  1  a pass is in progress.
REQ-016 done  output  1  one-cycle pulse marking the end of a pass.

Function
REQ-017 States SHALL be IDLE, RUN and FIN; reset SHALL enter IDLE.
REQ-018 In IDLE, start=1 SHALL latch all cfg_* inputs and go to RUN, or to FIN if the configuration is degenerate.
- Degenerate means K=0, W=0, H=0, K>W or K>H.
REQ-019 In RUN and FIN, start SHALL be ignored, and cfg_* changes SHALL have no effect.
REQ-020 The pass SHALL visit the loops kx, ky, ox, oy in that order, innermost first.
- kx and ky run 0..K-1.
- ox runs 0..W-K; oy runs 0..H-K.
REQ-021 addr SHALL equal cfg_base + (oy+ky)*W + (ox+kx), truncated modulo 2^ADDR_W; wrap-around is permitted and is not flagged.
REQ-022 addr, addr_valid and win_last SHALL be registered outputs.
- First address valid in the cycle after start is sampled (latency 1).
REQ-023 A transfer SHALL occur on each rising edge where addr_valid=1 and stall=0.
- On a transfer the loops advance and the next address appears in the following cycle.
- There is no bubble between consecutive addresses.
REQ-024 While stall=1, addr, addr_valid and win_last SHALL hold unchanged.
REQ-025 win_last SHALL be 1 exactly when kx=K-1 and ky=K-1.
REQ-026 When the final transfer occurs (kx=K-1, ky=K-1, ox=W-K, oy=H-K), the block SHALL go to FIN.
- addr_valid SHALL be 0 in the next cycle.
REQ-027 FIN SHALL last exactly one cycle, with done=1, then return to IDLE.
- A start in that FIN cycle SHALL be ignored.
REQ-028 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
- A new start SHALL be accepted in the first IDLE cycle after FIN.
REQ-029 Total transfers per pass SHALL be (W-K+1)*(H-K+1)*K*K.
- Internal loop counters and the product SHALL be sized so this count is never truncated for any legal DIM_W/K_W input.

Reset
REQ-030 reset_n=0 SHALL, asynchronously, force the state to IDLE and clear all loop counters.
- Outputs during reset: addr_valid=0, addr=0, win_last=0, busy=0, done=0.
REQ-031 Reset asserted mid-pass SHALL abort the pass with no done pulse.
- After release, the block SHALL stay in IDLE until the next start.

Verification
REQ-032 Nominal pass, W=4, H=4, K=3, base=0:
- First window: 0,1,2,4,5,6,8,9,10.
- Second window: 1,2,3,5,6,7,9,10,11.
- Last address is 15; 36 transfers in total.
- win_last is high on every 9th transfer.
- done pulses one cycle after the 36th transfer.
REQ-033 Pointwise kernel, K=1, W=2, H=2, base=100:
- Addresses 100,101,102,103 with win_last=1 on each.
- busy high for 5 cycles.
REQ-034 Degenerate configuration, K=5, W=4, H=4:
- addr_valid never rises.
- done pulses exactly one cycle after start; busy high for that single cycle.
REQ-035 Stall, nominal 4/4/3 configuration, stall=1 for 3 cycles while addr=5:
- addr holds at 5 for 4 cycles, then 6 follows.
- Transfer count stays 36.
REQ-036 Reset and start interaction:
- reset_n pulsed low mid-pass: outputs zero immediately and no done pulse.
- start during RUN: no effect on the address sequence.
- base=0xFFFE, W=2, H=1, K=1: addresses 0xFFFE, 0xFFFF.

Source files
------------

// File: rtl/conv_win_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_win_addr_gen
//
// Generates the feature-map read addresses for a stride-1 KxK convolution
// sweep. Loops nest kx (innermost), ky, ox, oy (outermost) and each tap reads
// address base + (oy+ky)*W + (ox+kx), truncated to ADDR_W bits.
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       one-cycle request to run one pass (sampled only in IDLE)
//   cfg_base    feature-map base address
//   cfg_width   input map width W
//   cfg_height  input map height H
//   cfg_kernel  square kernel size K
//   stall       downstream hold; the presented address is not consumed
//   addr_valid  addr carries a valid read address (registered)
//   addr        read address (registered)
//   win_last    addr is the last tap of the current window (registered)
//   busy        pass in progress (RUN or FIN)
//   done        one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module conv_win_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int K_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [K_W-1:0]    cfg_kernel,
    input  logic              stall,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    // Wide enough for base + (H-1)*W + (W-1) without losing bits before the
    // final modulo-2^ADDR_W truncation.
    localparam int CW = (ADDR_W > 2 * DIM_W + 2) ? ADDR_W : 2 * DIM_W + 2;
    // Common width for comparing K against W/H.
    localparam int MW = (DIM_W > K_W) ? DIM_W : K_W;

    localparam logic [K_W-1:0]   K_ONE  = {{(K_W-1){1'b0}}, 1'b1};
    localparam logic [K_W-1:0]   K_ZERO = {K_W{1'b0}};
    localparam logic [DIM_W-1:0] D_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0] D_ZERO = {DIM_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    // Latched configuration, stored as loop limits
    logic [ADDR_W-1:0] base_r;
    logic [DIM_W-1:0]  width_r;
    logic [K_W-1:0]    kmax_r;
    logic [DIM_W-1:0]  oxmax_r;
    logic [DIM_W-1:0]  oymax_r;

    // Loop counters
    logic [K_W-1:0]   kx_r, ky_r, kx_s, ky_s;
    logic [DIM_W-1:0] ox_r, oy_r, ox_s, oy_s;

    // Registered outputs and their next values
    logic              addr_valid_r, addr_valid_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              win_last_r, win_last_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    logic              accept_s;
    logic              degenerate_s;
    logic              xfer_s;
    logic              last_xfer_s;
    logic [ADDR_W-1:0] base_sel_s;
    logic [DIM_W-1:0]  width_sel_s;
    logic [K_W-1:0]    kmax_sel_s;
    logic [CW-1:0]     row_s;
    logic [CW-1:0]     col_s;
    logic [CW-1:0]     full_addr_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    // Degenerate configuration check on the live cfg inputs
    always_comb begin
        degenerate_s = (cfg_kernel == K_ZERO) || (cfg_width == D_ZERO) ||
                       (cfg_height == D_ZERO) ||
                       (MW'(cfg_kernel) > MW'(cfg_width)) ||
                       (MW'(cfg_kernel) > MW'(cfg_height));
    end

    assign xfer_s      = (state_r == ST_RUN) && addr_valid_r && !stall;
    assign last_xfer_s = xfer_s && (kx_r == kmax_r) && (ky_r == kmax_r) &&
                         (ox_r == oxmax_r) && (oy_r == oymax_r);

    // On the accept cycle the first address must come from the cfg inputs,
    // since the configuration registers are only written on that edge.
    assign base_sel_s  = accept_s ? cfg_base : base_r;
    assign width_sel_s = accept_s ? cfg_width : width_r;
    assign kmax_sel_s  = accept_s ? (cfg_kernel - K_ONE) : kmax_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = degenerate_s ? ST_FIN : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_xfer_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Loop counter next values: kx innermost, then ky, ox, oy
    always_comb begin
        kx_s = kx_r;
        ky_s = ky_r;
        ox_s = ox_r;
        oy_s = oy_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    kx_s = K_ZERO;
                    ky_s = K_ZERO;
                    ox_s = D_ZERO;
                    oy_s = D_ZERO;
                end else begin
                    kx_s = kx_r;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    if (kx_r != kmax_r) begin
                        kx_s = kx_r + K_ONE;
                    end else begin
                        kx_s = K_ZERO;
                        if (ky_r != kmax_r) begin
                            ky_s = ky_r + K_ONE;
                        end else begin
                            ky_s = K_ZERO;
                            if (ox_r != oxmax_r) begin
                                ox_s = ox_r + D_ONE;
                            end else begin
                                ox_s = D_ZERO;
                                if (oy_r != oymax_r) begin
                                    oy_s = oy_r + D_ONE;
                                end else begin
                                    oy_s = D_ZERO;
                                end
                            end
                        end
                    end
                end else begin
                    kx_s = kx_r;
                end
            end
            ST_FIN: begin
                kx_s = kx_r;
            end
            default: begin
                kx_s = K_ZERO;
                ky_s = K_ZERO;
                ox_s = D_ZERO;
                oy_s = D_ZERO;
            end
        endcase
    end

    // Address arithmetic on the next counter values, in a wide width
    always_comb begin
        row_s       = CW'(oy_s) + CW'(ky_s);
        col_s       = CW'(ox_s) + CW'(kx_s);
        full_addr_s = CW'(base_sel_s) + (row_s * CW'(width_sel_s)) + col_s;
    end

    // Next values of the registered outputs
    always_comb begin
        addr_valid_s = (state_s == ST_RUN);
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_FIN);
        if (addr_valid_s) begin
            addr_s     = full_addr_s[ADDR_W-1:0];
            win_last_s = (kx_s == kmax_sel_s) && (ky_s == kmax_sel_s);
        end else begin
            addr_s     = addr_r;
            win_last_s = 1'b0;
        end
    end

    // Loop counters and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kx_r         <= K_ZERO;
            ky_r         <= K_ZERO;
            ox_r         <= D_ZERO;
            oy_r         <= D_ZERO;
            addr_valid_r <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            win_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            kx_r         <= kx_s;
            ky_r         <= ky_s;
            ox_r         <= ox_s;
            oy_r         <= oy_s;
            addr_valid_r <= addr_valid_s;
            addr_r       <= addr_s;
            win_last_r   <= win_last_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    // Configuration latch, written only when a start is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r  <= {ADDR_W{1'b0}};
            width_r <= D_ZERO;
            kmax_r  <= K_ZERO;
            oxmax_r <= D_ZERO;
            oymax_r <= D_ZERO;
        end else if (accept_s) begin
            base_r  <= cfg_base;
            width_r <= cfg_width;
            kmax_r  <= cfg_kernel - K_ONE;
            oxmax_r <= cfg_width - DIM_W'(cfg_kernel);
            oymax_r <= cfg_height - DIM_W'(cfg_kernel);
        end else begin
            base_r  <= base_r;
            width_r <= width_r;
            kmax_r  <= kmax_r;
            oxmax_r <= oxmax_r;
            oymax_r <= oymax_r;
        end
    end

    assign addr_valid = addr_valid_r;
    assign addr       = addr_r;
    assign win_last   = win_last_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
